// File: rtl/bin_bcd_seq.sv
// bin_bcd_seq: sequential shift-add-3 binary-to-BCD converter with start/done handshake
// Ports:
//   clk_50M, rst_n : system clock (rising edge), asynchronous active-low reset
//   start, bin     : conversion request (sampled only in IDLE), value captured on accept
//   busy, done     : conversion in progress, one-cycle pulse when bcd/ovf update
//   bcd, ovf       : held result (digit 0 = ones), overflow flag (bcd saturated to all 9s)
module bin_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk_50M,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t          state_q;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    dig_q, adj, dig_d, bcd_q;
  logic [CW-1:0]    cnt_q;
  logic             sticky_q, sticky_d, busy_q, done_q, ovf_q;
  // One double-dabble iteration: correct every digit, then shift the next bit in.
  // A bit leaving the top digit means the value cannot fit in DIGITS digits.
  always_comb begin
    adj = dig_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = dig_q[4*i +: 4] >= 4'd5 ? dig_q[4*i +: 4] + 4'd3 : dig_q[4*i +: 4];
    dig_d    = {adj[BW-2:0], sr_q[WIDTH-1]};
    sr_d     = sr_q << 1;
    sticky_d = sticky_q | adj[BW-1];
  end
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      dig_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          sr_q     <= bin;
          dig_q    <= '0;
          sticky_q <= 1'b0;
          cnt_q    <= '0;
          busy_q   <= 1'b1;
          state_q  <= SHIFT;
        end
      end else begin
        sr_q     <= sr_d;
        dig_q    <= dig_d;
        sticky_q <= sticky_d;
        cnt_q    <= cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          bcd_q   <= sticky_d ? {DIGITS{4'h9}} : dig_d;
          ovf_q   <= sticky_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      end
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_bin_bcd_seq.sv
// tb_bin_bcd_seq: scoreboard bench for bin_bcd_seq (3-digit and 2-digit instances)
module tb_bin_bcd_seq;
  typedef struct packed {logic ovf; logic [11:0] bcd;} exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic [7:0]  bin_a = '0, bin_b = '0;
  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  exp_t        qa[$], qb[$];
  logic [11:0] last_a = '0;
  int          checks = 0, errors = 0, lat, bc, nd;
  always #5 clk = ~clk;
  bin_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
    .clk_50M(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a));
  bin_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
    .clk_50M(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b));
  function automatic exp_t model(int v, int lim);
    exp_t r;
    r.ovf = v > lim;
    r.bcd = r.ovf ? 12'h999 : {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    return r;
  endfunction
  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, g, e);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_a) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_done got ovf=%0b bcd=%h exp no done", ovf_a, bcd_a);
      end else begin
        e = qa.pop_front();
        if ({ovf_a, bcd_a} !== e) begin
          errors++;
          $display("FAIL a_result got ovf=%0b bcd=%h exp ovf=%0b bcd=%h", ovf_a, bcd_a, e.ovf, e.bcd);
        end
        last_a = e.bcd;
      end
    end
    if (rst_n && done_b) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_done got ovf=%0b bcd=%h exp no done", ovf_b, bcd_b);
      end else begin
        e = qb.pop_front();
        if ({ovf_b, bcd_b} !== {e.ovf, e.bcd[7:0]}) begin
          errors++;
          $display("FAIL b_result got ovf=%0b bcd=%h exp ovf=%0b bcd=%h", ovf_b, bcd_b, e.ovf, e.bcd[7:0]);
        end
      end
    end
  end
  task automatic go(input bit sel, input int v, input exp_t e, output int l, output int b);
    @(negedge clk);
    if (sel) begin bin_b = 8'(v); start_b = 1'b1; qb.push_back(e); end
    else begin bin_a = 8'(v); start_a = 1'b1; qa.push_back(e); end
    l = 0;
    b = 0;
    do begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      l++;
      if (sel ? busy_b : busy_a) b++;
    end while (!(sel ? done_b : done_a) && l < 40);
    checks++;
    if (l >= 40) begin
      errors++;
      $display("FAIL done_timeout got no done in %0d cycles exp done", l);
    end
  endtask
  int          dv[6] = '{255, 0, 9, 10, 99, 100};
  logic [11:0] de[6] = '{12'h255, 12'h000, 12'h009, 12'h010, 12'h099, 12'h100};
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_a", 32'({busy_a, done_a, ovf_a, bcd_a}), 0);
    chk("reset_b", 32'({busy_b, done_b, ovf_b, bcd_b}), 0);
    rst_n = 1'b1;
    go(0, dv[0], {1'b0, de[0]}, lat, bc);
    chk("t1_latency", 32'(lat), 9);
    chk("t1_busy_cycles", 32'(bc), 8);
    @(negedge clk);
    chk("t1_done_one_cycle", 32'(done_a), 0);
    for (int i = 1; i < 6; i++) go(0, dv[i], {1'b0, de[i]}, lat, bc);
    @(negedge clk);
    bin_a = 8'd37;
    start_a = 1'b1;
    qa.push_back({1'b0, 12'h037});
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy_a) chk("t3_bcd_hold", 32'(bcd_a), 32'h100);
      if (done_a) nd++;
      bin_a = 8'd200;
      start_a = busy_a;
    end
    start_a = 1'b0;
    chk("t3_single_done", 32'(nd), 1);
    @(negedge clk);
    start_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bin_a = 8'(i);
      qa.push_back({1'b0, 12'(i)});
      repeat (9) @(negedge clk);
      chk("t4_period", 32'(done_a), 1);
    end
    start_a = 1'b0;
    @(negedge clk);
    bin_a = 8'd180;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_out", 32'({busy_a, done_a, ovf_a, bcd_a}), 0);
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_done", 32'(done_a), 0);
    end
    rst_n = 1'b1;
    go(0, 180, {1'b0, 12'h180}, lat, bc);
    go(1, 100, {1'b1, 12'h099}, lat, bc);
    go(1, 42, {1'b0, 12'h042}, lat, bc);
    go(1, 255, {1'b1, 12'h099}, lat, bc);
    go(1, 99, {1'b0, 12'h099}, lat, bc);
    for (int v = 0; v < 256; v++) go(0, v, model(v, 999), lat, bc);
    repeat (5) @(negedge clk);
    chk("queue_a_empty", 32'(qa.size()), 0);
    chk("queue_b_empty", 32'(qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
